// File: rtl/l2_noc1_msg_assembler.sv
// Assembles NoC1 header + up to MAX_LEN payload flits into one message for the L2 pipeline.
// Oversize messages are consumed and dropped, with a one-cycle err_len pulse.
module l2_noc1_msg_assembler #(
  parameter int unsigned MAX_LEN = 2,
  localparam int unsigned DW = 64,
  localparam int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          noc1_valid_in,
  input  logic [DW-1:0] noc1_data_in,
  output logic          noc1_ready_in,
  output logic          msg_valid,
  input  logic          msg_ready,
  output logic [DW-1:0] msg_header,
  output logic [DW-1:0] msg_addr,
  output logic [DW-1:0] msg_data,
  output logic [1:0]    msg_len,
  output logic          err_len
);

  typedef enum logic [2:0] {S_HDR, S_PAY1, S_PAY2, S_OUT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] drop_cnt_q;
  logic          flit_acc;
  logic          msg_acc;
  logic [LW-1:0] hdr_len;
  logic          hdr_oversize;

  assign flit_acc     = noc1_valid_in & noc1_ready_in;
  assign msg_acc      = msg_valid & msg_ready;
  assign hdr_len      = noc1_data_in[29:22];
  assign hdr_oversize = 32'(hdr_len) > MAX_LEN;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (flit_acc) begin
          if (hdr_len == '0)     state_d = S_OUT;
          else if (hdr_oversize) state_d = S_DROP;
          else                   state_d = S_PAY1;
        end
      end
      S_PAY1: if (flit_acc) state_d = (len_q == LW'(1)) ? S_OUT : S_PAY2;
      S_PAY2: if (flit_acc) state_d = S_OUT;
      S_OUT:  if (msg_acc)  state_d = S_HDR;
      S_DROP: if (flit_acc && drop_cnt_q == LW'(1)) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  // State and handshake outputs, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HDR;
      noc1_ready_in <= 1'b1;
      msg_valid     <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      state_q       <= state_d;
      noc1_ready_in <= (state_d != S_OUT);
      msg_valid     <= (state_d == S_OUT);
      err_len       <= (state_q == S_HDR) && flit_acc && hdr_oversize;
    end
  end

  // Message payload capture; absent payload slots are cleared at header time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_header <= '0;
      msg_addr   <= '0;
      msg_data   <= '0;
      msg_len    <= '0;
      len_q      <= '0;
      drop_cnt_q <= '0;
    end else if (flit_acc) begin
      if (state_q == S_HDR) begin
        len_q <= hdr_len;
        if (hdr_oversize) begin
          drop_cnt_q <= hdr_len;
        end else begin
          msg_header <= noc1_data_in;
          msg_addr   <= '0;
          msg_data   <= '0;
          msg_len    <= 2'(hdr_len);
        end
      end else if (state_q == S_PAY1) begin
        msg_addr <= noc1_data_in;
      end else if (state_q == S_PAY2) begin
        msg_data <= noc1_data_in;
      end else if (state_q == S_DROP) begin
        drop_cnt_q <= drop_cnt_q - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_l2_noc1_msg_assembler.sv
// Bench for l2_noc1_msg_assembler: directed scenarios plus a randomized run against a message-level scoreboard.
module tb_l2_noc1_msg_assembler;

  logic        clk;
  logic        rst;
  logic        noc1_valid_in;
  logic [63:0] noc1_data_in;
  logic        noc1_ready_in;
  logic        msg_valid;
  logic        msg_ready;
  logic [63:0] msg_header;
  logic [63:0] msg_addr;
  logic [63:0] msg_data;
  logic [1:0]  msg_len;
  logic        err_len;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [63:0] h;
    logic [63:0] a;
    logic [63:0] d;
    logic [1:0]  l;
  } msg_t;

  l2_noc1_msg_assembler #(.MAX_LEN(2)) dut (
    .clk(clk), .rst(rst),
    .noc1_valid_in(noc1_valid_in), .noc1_data_in(noc1_data_in), .noc1_ready_in(noc1_ready_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_header(msg_header), .msg_addr(msg_addr), .msg_data(msg_data),
    .msg_len(msg_len), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk_hdr(input int unsigned len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[29:22] = 8'(len);
    return h;
  endfunction

  // Present one flit and wait (bounded) until it is accepted; returns #1 after the accepting edge
  task automatic send_flit(input logic [63:0] d);
    int n = 0;
    noc1_valid_in = 1'b1;
    noc1_data_in  = d;
    while (noc1_ready_in !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL send_timeout got ready=%b exp ready=1 within 50 cycles", noc1_ready_in);
    end else begin
      @(posedge clk); #1;
    end
    noc1_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; noc1_valid_in = 1'b0; noc1_data_in = '0; msg_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++; if (noc1_ready_in !== 1'b1) $display("FAIL rst_ready got=%b exp=1", noc1_ready_in); else n_pass++;
    n_total++; if (msg_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", msg_valid); else n_pass++;
    n_total++; if (err_len !== 1'b0) $display("FAIL rst_err got=%b exp=0", err_len); else n_pass++;
    n_total++; if ({msg_header, msg_addr, msg_data, msg_len} !== '0)
      $display("FAIL rst_data got=%h/%h/%h/%0d exp=0", msg_header, msg_addr, msg_data, msg_len); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_len0();
    logic [63:0] h;
    h = mk_hdr(0);
    msg_ready = 1'b1;
    send_flit(h);
    n_total++; if (msg_valid !== 1'b1) $display("FAIL len0_valid got=%b exp=1", msg_valid); else n_pass++;
    n_total++; if (msg_len !== 2'd0 || msg_addr !== 64'd0 || msg_data !== 64'd0 || msg_header !== h)
      $display("FAIL len0_fields got len=%0d addr=%h data=%h hdr=%h exp len=0 addr=0 data=0 hdr=%h",
               msg_len, msg_addr, msg_data, msg_header, h); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (msg_valid !== 1'b0 || noc1_ready_in !== 1'b1)
      $display("FAIL len0_return got valid=%b ready=%b exp valid=0 ready=1", msg_valid, noc1_ready_in); else n_pass++;
    msg_ready = 1'b0;
  endtask

  task automatic test_len2();
    logic [63:0] h;
    h = mk_hdr(2);
    msg_ready = 1'b0;
    send_flit(h);
    send_flit(64'hA);
    n_total++; if (msg_valid !== 1'b0) $display("FAIL len2_early got=%b exp=0", msg_valid); else n_pass++;
    send_flit(64'hB);
    n_total++; if (msg_valid !== 1'b1 || msg_addr !== 64'hA || msg_data !== 64'hB || msg_len !== 2'd2 || msg_header !== h)
      $display("FAIL len2_msg got valid=%b addr=%h data=%h len=%0d exp valid=1 addr=a data=b len=2",
               msg_valid, msg_addr, msg_data, msg_len); else n_pass++;
    msg_ready = 1'b1;
    @(posedge clk); #1;
    msg_ready = 1'b0;
    n_total++; if (msg_valid !== 1'b0) $display("FAIL len2_done got=%b exp=0", msg_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] h;
    logic [63:0] p;
    h = mk_hdr(1);
    p = {$urandom, $urandom};
    msg_ready = 1'b0;
    send_flit(h);
    send_flit(p);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (msg_valid !== 1'b1 || noc1_ready_in !== 1'b0 || msg_header !== h || msg_addr !== p ||
          msg_data !== 64'd0 || msg_len !== 2'd1)
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b addr=%h data=%h len=%0d exp valid=1 ready=0 addr=%h data=0 len=1",
                 i, msg_valid, noc1_ready_in, msg_addr, msg_data, msg_len, p);
      else n_pass++;
      @(posedge clk); #1;
    end
    msg_ready = 1'b1;
    @(posedge clk); #1;
    msg_ready = 1'b0;
    n_total++; if (msg_valid !== 1'b0 || noc1_ready_in !== 1'b1)
      $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", msg_valid, noc1_ready_in); else n_pass++;
  endtask

  task automatic test_drop();
    logic [63:0] h;
    logic [63:0] p;
    int errs;
    int vals;
    msg_ready = 1'b1;
    // length 5: one err pulse, nothing delivered
    send_flit(mk_hdr(5));
    n_total++; if (err_len !== 1'b1) $display("FAIL drop_err_pulse got=%b exp=1", err_len); else n_pass++;
    errs = 0; vals = 0;
    for (int i = 0; i < 5; i++) begin
      send_flit({$urandom, $urandom});
      errs += int'(err_len);
      vals += int'(msg_valid);
    end
    n_total++; if (errs != 0 || vals != 0)
      $display("FAIL drop5_quiet got err=%0d valid=%0d exp err=0 valid=0", errs, vals); else n_pass++;
    h = mk_hdr(0);
    send_flit(h);
    n_total++; if (msg_valid !== 1'b1 || msg_len !== 2'd0 || msg_header !== h)
      $display("FAIL drop5_next got valid=%b len=%0d hdr=%h exp valid=1 len=0 hdr=%h", msg_valid, msg_len, msg_header, h); else n_pass++;
    @(posedge clk); #1;
    // length 255: exactly 255 flits absorbed, then a normal length-1 message
    send_flit(mk_hdr(255));
    errs = int'(err_len); vals = 0;
    for (int i = 0; i < 255; i++) begin
      send_flit({$urandom, $urandom});
      errs += int'(err_len);
      vals += int'(msg_valid);
    end
    n_total++; if (errs != 1 || vals != 0)
      $display("FAIL drop255_quiet got err=%0d valid=%0d exp err=1 valid=0", errs, vals); else n_pass++;
    h = mk_hdr(1);
    p = {$urandom, $urandom};
    send_flit(h);
    send_flit(p);
    n_total++; if (msg_valid !== 1'b1 || msg_header !== h || msg_addr !== p || msg_len !== 2'd1)
      $display("FAIL drop255_next got valid=%b hdr=%h addr=%h len=%0d exp valid=1 hdr=%h addr=%h len=1",
               msg_valid, msg_header, msg_addr, msg_len, h, p); else n_pass++;
    @(posedge clk); #1;
    msg_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] h;
    int vals;
    msg_ready = 1'b1;
    send_flit(mk_hdr(2));
    send_flit({$urandom, $urandom});
    rst = 1'b1;
    #1;
    n_total++; if (noc1_ready_in !== 1'b1 || msg_addr !== 64'd0 || msg_valid !== 1'b0)
      $display("FAIL rstmid_async got ready=%b addr=%h valid=%b exp ready=1 addr=0 valid=0", noc1_ready_in, msg_addr, msg_valid); else n_pass++;
    #2 rst = 1'b0;
    vals = 0;
    repeat (3) begin
      @(posedge clk); #1;
      vals += int'(msg_valid);
    end
    n_total++; if (vals != 0) $display("FAIL rstmid_novalid got=%0d exp=0", vals); else n_pass++;
    h = mk_hdr(0);
    send_flit(h);
    n_total++; if (msg_valid !== 1'b1 || msg_len !== 2'd0 || msg_header !== h)
      $display("FAIL rstmid_next got valid=%b len=%0d hdr=%h exp valid=1 len=0 hdr=%h", msg_valid, msg_len, msg_header, h); else n_pass++;
    @(posedge clk); #1;
    msg_ready = 1'b0;
  endtask

  task automatic test_random();
    msg_t        exp_q[$];
    logic [63:0] flit_q[$];
    msg_t        m;
    msg_t        e;
    int unsigned len;
    int          cyc;
    // Build the message stream and the expected deliveries
    for (int i = 0; i < 1000; i++) begin
      len = $urandom_range(0, 2);
      m.h = mk_hdr(len);
      m.a = (len >= 1) ? {$urandom, $urandom} : 64'd0;
      m.d = (len == 2) ? {$urandom, $urandom} : 64'd0;
      m.l = 2'(len);
      flit_q.push_back(m.h);
      if (len >= 1) flit_q.push_back(m.a);
      if (len == 2) flit_q.push_back(m.d);
      exp_q.push_back(m);
    end
    cyc = 0;
    while ((flit_q.size() > 0 || exp_q.size() > 0) && cyc < 40000) begin
      noc1_valid_in = (flit_q.size() > 0) && ($urandom_range(0, 3) != 0);
      noc1_data_in  = noc1_valid_in ? flit_q[0] : {$urandom, $urandom};
      msg_ready     = ($urandom_range(0, 2) != 0);
      if (noc1_valid_in && noc1_ready_in) void'(flit_q.pop_front());
      if (msg_valid && msg_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra got hdr=%h exp no message", msg_header);
        end else begin
          e = exp_q.pop_front();
          if (msg_header !== e.h || msg_addr !== e.a || msg_data !== e.d || msg_len !== e.l)
            $display("FAIL rand_msg got %h/%h/%h/%0d exp %h/%h/%h/%0d",
                     msg_header, msg_addr, msg_data, msg_len, e.h, e.a, e.d, e.l);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    noc1_valid_in = 1'b0;
    msg_ready = 1'b0;
    n_total++;
    if (flit_q.size() > 0 || exp_q.size() > 0)
      $display("FAIL rand_drain got flits=%0d msgs=%0d left exp 0/0", flit_q.size(), exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len2();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_noc1_msg_assembler.md
L2_NOC1_MSG_ASSEMBLER -- requirements
Module: l2_noc1_msg_assembler

Interface
REQ-001 SHALL have parameter MAX_LEN, default 2, meaning the largest payload flit count accepted as a message.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port noc1_valid_in, input, 1, NoC1 flit valid.
REQ-005 SHALL have port noc1_data_in, input, 64, NoC1 flit.
REQ-006 SHALL have port noc1_ready_in, output, 1, assembler can accept a flit.
REQ-007 SHALL have port msg_valid, output, 1, an assembled message is presented to the L2 pipeline.
REQ-008 SHALL have port msg_ready, input, 1, the L2 pipeline accepts the message.
REQ-009 SHALL have port msg_header, output, 64, the header flit as received.
REQ-010 SHALL have port msg_addr, output, 64, payload flit 1.
REQ-011 SHALL have port msg_data, output, 64, payload flit 2.
REQ-012 SHALL have port msg_len, output, 2, payload flit count of the presented message (0..MAX_LEN).
REQ-013 SHALL have port err_len, output, 1, one-cycle pulse when an oversize message is dropped.

Function
REQ-014 Flit transfer SHALL occur only in a cycle where noc1_valid_in and noc1_ready_in are both 1.
REQ-015 Message transfer SHALL occur only in a cycle where msg_valid and msg_ready are both 1.
REQ-016 Header fields: length = noc1_data_in[29:22] (8 bits, unsigned); all other header bits SHALL pass through unmodified.
REQ-017 FSM states SHALL be S_HDR, S_PAY1, S_PAY2, S_OUT and S_DROP; reset state is S_HDR.
REQ-018 noc1_ready_in SHALL be 1 in S_HDR, S_PAY1, S_PAY2 and S_DROP, and 0 in S_OUT.
REQ-019 msg_valid SHALL be 1 only in S_OUT, and SHALL be a registered output.
REQ-020 S_HDR with header accepted: length 0 -> S_OUT; length 1 or 2 -> S_PAY1; length > MAX_LEN -> S_DROP with err_len = 1 in the following cycle.
REQ-021 S_PAY1 with flit accepted: capture the flit into msg_addr; if length = 1 -> S_OUT, else -> S_PAY2.
REQ-022 S_PAY2 with flit accepted: capture the flit into msg_data; -> S_OUT.
REQ-023 Latency: msg_valid SHALL rise in the cycle after the last flit of the message is accepted (after the header when length = 0).
REQ-024 S_OUT: msg_header, msg_addr, msg_data and msg_len SHALL hold stable until message transfer; on transfer -> S_HDR next cycle.
REQ-025 msg_addr and msg_data SHALL be 0 for payload positions not present in the message (msg_addr zeroed when length = 0; msg_data zeroed when length <= 1).
REQ-026 S_DROP: an 8-bit down-counter loaded with length SHALL decrement once per accepted flit; the flit that takes the counter from 1 to 0 -> S_HDR; no message SHALL be emitted.
REQ-027 Length 255 SHALL drop exactly 255 payload flits with no counter wrap.
REQ-028 Holding noc1_valid_in = 0 mid-message SHALL stall the FSM in its current state with no data change.
REQ-029 Holding msg_ready = 0 SHALL hold S_OUT indefinitely with noc1 fully backpressured (noc1_ready_in = 0).
REQ-030 Raising msg_ready while msg_valid = 0 SHALL have no effect.

Reset
REQ-031 rst asserted SHALL immediately (asynchronously) force: state S_HDR; noc1_ready_in = 1 once in S_HDR; msg_valid = 0, err_len = 0; msg_header, msg_addr, msg_data = 0; msg_len = 0; drop counter = 0.
REQ-032 Reset asserted mid-message or during S_DROP SHALL discard the partial message; the first accepted flit after deassertion SHALL be treated as a header.

Verification
REQ-033 Header with length 0, msg_ready = 1 -> msg_valid = 1 the next cycle, msg_len = 0, msg_addr = 0; back in S_HDR the cycle after.
REQ-034 Header with length 2, then flits 0xA and 0xB with no gaps -> msg_valid = 1 in the cycle after 0xB, msg_addr = 0xA, msg_data = 0xB, msg_len = 2.
REQ-035 Length 1 message with msg_ready = 0 for 5 cycles -> outputs stable, noc1_ready_in = 0 for those 5 cycles, transfer on cycle 6.
REQ-036 Header with length 5, then 5 flits, then a header with length 0 -> err_len pulses once, no message for the dropped flits, then one message with msg_len = 0.
REQ-037 rst pulsed after the header and first payload of a length-2 message -> no msg_valid; the next header with length 0 yields msg_len = 0.
REQ-038 Random noc1_valid_in/msg_ready gaps over 1000 messages with length 0..2 -> every message is delivered in order and bit-exact against a scoreboard.
